// File: rtl/i2s_sample_queue.sv
// i2s_sample_queue
// Left-channel I2S deserialiser feeding a DEPTH-entry sign-extended sample
// window, presented in parallel (entry 0 = newest, top slice).
// Pushes happen on the LRCLK rise that ends a complete left word and are
// gated by LD_Q, so the window stays frozen while a snapshot is being read.
// Optional feature macro: I2S_QUEUE_FRAME_ERR_EN enables the saturating
// short-frame counter on FRAME_ERR_COUNT; without it the port reads 8'h00.
module i2s_sample_queue #(
    parameter int DEPTH    = 256,
    parameter int SAMPLE_W = 16,
    parameter int ENTRY_W  = 32
) (
    input  logic                       SCLK,
    input  logic                       RESET,
    input  logic                       LRCLK,
    input  logic                       ADCDAT,
    input  logic                       LD_Q,
    output logic [DEPTH*ENTRY_W-1:0]   queue_parallel_out,
    output logic                       SAMPLE_VALID,
    output logic [8:0]                 SAMPLE_COUNT,
    output logic                       FULL,
    output logic [7:0]                 FRAME_ERR_COUNT
);

    localparam int              CNT_W     = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
    localparam logic [8:0]      DEPTH_CNT = 9'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        HOLD
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [SAMPLE_W-1:0]    shreg_reg;
    logic                   lrclk_d_reg;

    logic [ENTRY_W-1:0]     queue_reg [DEPTH];
    logic [8:0]             count_reg;
    logic                   full_reg;
    logic                   sample_valid_reg;

    logic                   fall;
    logic                   rise;
    logic                   push_cycle;
    logic                   push_en;
    logic [ENTRY_W-1:0]     sample_ext;

    assign fall       = lrclk_d_reg & ~LRCLK;
    assign rise       = ~lrclk_d_reg & LRCLK;
    // The push cycle is the LRCLK rise seen while a complete word is held.
    assign push_cycle = (state_reg == HOLD) && rise;
    assign push_en    = push_cycle && LD_Q;
    assign sample_ext = {{(ENTRY_W - SAMPLE_W){shreg_reg[SAMPLE_W-1]}}, shreg_reg};

    // Deserialiser FSM: word-select edge detect, one-bit I2S delay, MSB-first shift.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            lrclk_d_reg <= 1'b1;
        end else begin
            lrclk_d_reg <= LRCLK;
            if (fall) begin
                // A fall anywhere (re)starts a left word; any partial word is dropped.
                state_reg <= DELAY;
            end else begin
                case (state_reg)
                    IDLE: state_reg <= IDLE;
                    DELAY: begin
                        bit_cnt_reg <= '0;
                        state_reg   <= SHIFT;
                    end
                    SHIFT: begin
                        if (rise) begin
                            // Word select flipped before a full word arrived: abort.
                            state_reg <= IDLE;
                        end else begin
                            shreg_reg   <= {shreg_reg[SAMPLE_W-2:0], ADCDAT};
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (rise) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Sample window: newest sample enters entry 0, the oldest falls off the end.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                queue_reg[k] <= '0;
            end
        end else if (push_en) begin
            queue_reg[0] <= sample_ext;
            for (int k = 1; k < DEPTH; k++) begin
                queue_reg[k] <= queue_reg[k-1];
            end
        end
    end

    // Fill level, full flag and the one-cycle valid pulse that tracks each update.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            count_reg        <= '0;
            full_reg         <= 1'b0;
            sample_valid_reg <= 1'b0;
        end else begin
            sample_valid_reg <= push_en;
            if (push_en && (count_reg != DEPTH_CNT)) begin
                count_reg <= count_reg + 9'd1;
                full_reg  <= ((count_reg + 9'd1) == DEPTH_CNT);
            end
        end
    end

    // Entry k occupies the k-th ENTRY_W slice counting down from the MSB.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign queue_parallel_out[DEPTH*ENTRY_W-1-gi*ENTRY_W -: ENTRY_W] = queue_reg[gi];
        end
    endgenerate

    assign SAMPLE_VALID = sample_valid_reg;
    assign SAMPLE_COUNT = count_reg;
    assign FULL         = full_reg;

`ifdef I2S_QUEUE_FRAME_ERR_EN
    logic       abort_cycle;
    logic [7:0] frame_err_reg;

    assign abort_cycle = (state_reg == SHIFT) && rise;

    // Saturating count of short (aborted) left words.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            frame_err_reg <= 8'h00;
        end else if (abort_cycle && (frame_err_reg != 8'hFF)) begin
            frame_err_reg <= frame_err_reg + 8'h01;
        end
    end

    assign FRAME_ERR_COUNT = frame_err_reg;
`else
    assign FRAME_ERR_COUNT = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_sample_queue.sv
// Testbench for i2s_sample_queue: drives I2S frames (20-cycle halves),
// keeps a scoreboard of expected newest samples plus a window model.
module tb_i2s_sample_queue;

    localparam int DEPTH    = 256;
    localparam int SAMPLE_W = 16;
    localparam int ENTRY_W  = 32;
`ifdef I2S_QUEUE_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                     SCLK = 1'b0;
    logic                     RESET;
    logic                     LRCLK;
    logic                     ADCDAT;
    logic                     LD_Q;
    logic [DEPTH*ENTRY_W-1:0] qpo;
    logic                     SAMPLE_VALID;
    logic [8:0]               SAMPLE_COUNT;
    logic                     FULL;
    logic [7:0]               FRAME_ERR_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_q [DEPTH];
    int          model_cnt;
    int          exp_err;
    logic [31:0] sb [$];

    i2s_sample_queue #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W),
        .ENTRY_W  (ENTRY_W)
    ) dut (
        .SCLK               (SCLK),
        .RESET              (RESET),
        .LRCLK              (LRCLK),
        .ADCDAT             (ADCDAT),
        .LD_Q               (LD_Q),
        .queue_parallel_out (qpo),
        .SAMPLE_VALID       (SAMPLE_VALID),
        .SAMPLE_COUNT       (SAMPLE_COUNT),
        .FULL               (FULL),
        .FRAME_ERR_COUNT    (FRAME_ERR_COUNT)
    );

    always #5 SCLK = ~SCLK;

    function automatic logic [31:0] entry(input int k);
        return qpo[DEPTH*ENTRY_W-1-k*ENTRY_W -: ENTRY_W];
    endfunction

    function automatic logic [7:0] exp_err_out();
        return ERR_EN ? 8'(exp_err) : 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) model_q[k] = '0;
        model_cnt = 0;
        exp_err   = 0;
        sb.delete();
    endtask

    task automatic apply_reset();
        RESET = 1'b1; LRCLK = 1'b1; LD_Q = 1'b0; ADCDAT = 1'b0;
        repeat (3) @(posedge SCLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // One frame: low (left) half of low_len cycles, then 20-cycle right half.
    task automatic send_frame(input logic [15:0] val, input logic ld, input int low_len);
        logic [31:0] ext;
        logic [31:0] got;
        bit          pushes;
        ext    = {{16{val[15]}}, val};
        pushes = ld && (low_len >= 18);
        if (pushes) begin
            sb.push_back(ext);
            for (int k = DEPTH - 1; k > 0; k--) model_q[k] = model_q[k-1];
            model_q[0] = ext;
            if (model_cnt < DEPTH) model_cnt++;
        end
        if (low_len < 18 && exp_err < 255) exp_err++;
        for (int t = 0; t < low_len; t++) begin
            LRCLK  = 1'b0;
            LD_Q   = ~ld;
            ADCDAT = (t >= 2 && t <= 17) ? val[17-t] : 1'($urandom_range(1, 0));
            @(posedge SCLK);
            #1;
        end
        for (int t = 0; t < 20; t++) begin
            LRCLK  = 1'b1;
            LD_Q   = (t == 0) ? ld : ~ld;
            ADCDAT = 1'($urandom_range(1, 0));
            if (t == 1) begin
                @(negedge SCLK);
                n_checks++;
                if (SAMPLE_VALID !== pushes) begin
                    n_fail++;
                    $display("FAIL valid_after_push: got %b expected %b (val %h)", SAMPLE_VALID, pushes, val);
                end
                if (pushes) begin
                    got = sb.pop_front();
                    n_checks++;
                    if (entry(0) !== got) begin
                        n_fail++;
                        $display("FAIL entry0_scoreboard: got %h expected %h", entry(0), got);
                    end
                end
            end
            if (t == 2) begin
                @(negedge SCLK);
                n_checks++;
                if (SAMPLE_VALID !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_one_pulse: got %b expected 0", SAMPLE_VALID);
                end
            end
            @(posedge SCLK);
            #1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge SCLK);
        n_checks++;
        if (SAMPLE_COUNT !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", SAMPLE_COUNT); end
        n_checks++;
        if (FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", FULL); end
        n_checks++;
        if (SAMPLE_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", SAMPLE_VALID); end
        n_checks++;
        if (FRAME_ERR_COUNT !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h expected 00", FRAME_ERR_COUNT); end
        n_checks++;
        if (qpo !== '0) begin n_fail++; $display("FAIL reset_queue: got nonzero window expected all zero"); end
        @(posedge SCLK);
        #1;
    endtask

    task automatic test_basic();
        send_frame(16'h8001, 1'b1, 20);
        n_checks++;
        if (entry(0) !== 32'hFFFF8001) begin n_fail++; $display("FAIL basic_entry0: got %h expected FFFF8001", entry(0)); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", SAMPLE_COUNT); end
        n_checks++;
        if (FULL !== 1'b0) begin n_fail++; $display("FAIL basic_full: got %b expected 0", FULL); end
        send_frame(16'h1234, 1'b1, 20);
        n_checks++;
        if (entry(0) !== 32'h00001234) begin n_fail++; $display("FAIL basic2_entry0: got %h expected 00001234", entry(0)); end
        n_checks++;
        if (entry(1) !== 32'hFFFF8001) begin n_fail++; $display("FAIL basic2_entry1: got %h expected FFFF8001", entry(1)); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'd2) begin n_fail++; $display("FAIL basic2_count: got %0d expected 2", SAMPLE_COUNT); end
    endtask

    task automatic test_ld_q_low();
        send_frame(16'h00AA, 1'b0, 20);
        n_checks++;
        if (entry(0) !== 32'h00001234) begin n_fail++; $display("FAIL ldq_entry0: got %h expected 00001234", entry(0)); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'(model_cnt)) begin n_fail++; $display("FAIL ldq_count: got %0d expected %0d", SAMPLE_COUNT, model_cnt); end
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (entry(k) !== model_q[k]) begin n_fail++; $display("FAIL ldq_entry%0d: got %h expected %h", k, entry(k), model_q[k]); end
        end
    endtask

    task automatic test_short_frame();
        send_frame(16'h0155, 1'b1, 12);
        n_checks++;
        if (FRAME_ERR_COUNT !== exp_err_out()) begin n_fail++; $display("FAIL short_err: got %h expected %h", FRAME_ERR_COUNT, exp_err_out()); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'(model_cnt)) begin n_fail++; $display("FAIL short_count: got %0d expected %0d", SAMPLE_COUNT, model_cnt); end
        n_checks++;
        if (entry(0) !== model_q[0]) begin n_fail++; $display("FAIL short_entry0: got %h expected %h", entry(0), model_q[0]); end
        send_frame(16'h0005, 1'b1, 20);
        n_checks++;
        if (entry(0) !== 32'h00000005) begin n_fail++; $display("FAIL after_short_entry0: got %h expected 00000005", entry(0)); end
        n_checks++;
        if (entry(1) !== 32'h00001234) begin n_fail++; $display("FAIL after_short_entry1: got %h expected 00001234", entry(1)); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'd3) begin n_fail++; $display("FAIL after_short_count: got %0d expected 3", SAMPLE_COUNT); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] val;
        val = 16'h5A5A;
        for (int t = 0; t < 20; t++) begin
            LRCLK  = 1'b0;
            LD_Q   = 1'b1;
            RESET  = (t == 8);
            ADCDAT = (t >= 2 && t <= 17) ? val[17-t] : 1'b0;
            if (t == 9) begin
                model_reset();
                @(negedge SCLK);
                n_checks++;
                if (SAMPLE_COUNT !== 9'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", SAMPLE_COUNT); end
                n_checks++;
                if (FULL !== 1'b0 || SAMPLE_VALID !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got full %b valid %b expected 0 0", FULL, SAMPLE_VALID); end
                n_checks++;
                if (FRAME_ERR_COUNT !== 8'h00) begin n_fail++; $display("FAIL midreset_err: got %h expected 00", FRAME_ERR_COUNT); end
                n_checks++;
                if (qpo !== '0) begin n_fail++; $display("FAIL midreset_queue: got nonzero window expected all zero"); end
            end
            @(posedge SCLK);
            #1;
        end
        // The fall seen right after reset starts a word that the rise cuts short.
        exp_err = 1;
        for (int t = 0; t < 20; t++) begin
            LRCLK = 1'b1; LD_Q = 1'b1; ADCDAT = 1'b0;
            @(posedge SCLK);
            #1;
        end
        n_checks++;
        if (SAMPLE_COUNT !== 9'd0) begin n_fail++; $display("FAIL midreset_nopush: got %0d expected 0", SAMPLE_COUNT); end
        n_checks++;
        if (FRAME_ERR_COUNT !== exp_err_out()) begin n_fail++; $display("FAIL midreset_abort_err: got %h expected %h", FRAME_ERR_COUNT, exp_err_out()); end
        send_frame(16'h7FFF, 1'b1, 20);
        n_checks++;
        if (entry(0) !== 32'h00007FFF) begin n_fail++; $display("FAIL midreset_entry0: got %h expected 00007FFF", entry(0)); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'd1) begin n_fail++; $display("FAIL midreset_count1: got %0d expected 1", SAMPLE_COUNT); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int v = 1; v <= 257; v++) begin
            send_frame(16'(v), 1'b1, 20);
            n_checks++;
            if (FULL !== (model_cnt == DEPTH)) begin n_fail++; $display("FAIL fill_full_%0d: got %b expected %b", v, FULL, (model_cnt == DEPTH)); end
            n_checks++;
            if (SAMPLE_COUNT !== 9'(model_cnt)) begin n_fail++; $display("FAIL fill_count_%0d: got %0d expected %0d", v, SAMPLE_COUNT, model_cnt); end
        end
        n_checks++;
        if (entry(0) !== 32'd257) begin n_fail++; $display("FAIL fill_entry0: got %h expected 00000101", entry(0)); end
        n_checks++;
        if (qpo[31:0] !== 32'd2) begin n_fail++; $display("FAIL fill_entry255: got %h expected 00000002", qpo[31:0]); end
        n_checks++;
        if (SAMPLE_COUNT !== 9'd256) begin n_fail++; $display("FAIL fill_count_final: got %0d expected 256", SAMPLE_COUNT); end
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (entry(k) !== model_q[k]) begin n_fail++; $display("FAIL fill_entry%0d: got %h expected %h", k, entry(k), model_q[k]); end
        end
    endtask

    initial begin
        RESET = 1'b1; LRCLK = 1'b1; LD_Q = 1'b0; ADCDAT = 1'b0;
        test_reset();
        test_basic();
        test_ld_q_low();
        test_short_frame();
        test_reset_mid_frame();
        test_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
